qspi_rle_fetch: RTL and testbench

QSPI_RLE_FETCH -- requirements
Module: qspi_rle_fetch

---
 rtl/qspi_rle_fetch_if.sv | 25 ++
 rtl/qspi_rle_fetch.sv | 195 +++++++++++++++++++
 tb/tb_qspi_rle_fetch.sv | 387 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/qspi_rle_fetch_if.sv
// Bus bundle for qspi_rle_fetch: QSPI flash pins plus the word stream.
// master = fetch engine side, slave = flash/consumer side.
interface qspi_rle_fetch_if;
    logic        spi_clk_out;
    logic        spi_cs_n;
    logic [3:0]  spi_d_out;
    logic [3:0]  spi_d_oe;
    logic [3:0]  spi_d_in;
    logic        read_next;
    logic        stop_data;
    logic        data_ready;
    logic [15:0] data;

    modport master (
        output spi_clk_out, spi_cs_n, spi_d_out, spi_d_oe,
        output data_ready, data,
        input  spi_d_in, read_next, stop_data
    );

    modport slave (
        input  spi_clk_out, spi_cs_n, spi_d_out, spi_d_oe,
        input  data_ready, data,
        output spi_d_in, read_next, stop_data
    );
endinterface

// File: rtl/qspi_rle_fetch.sv
// QSPI quad-IO (0xEB) stream fetcher feeding a 2-word FIFO.
// Ports: clk, rstn (sync, active-low), bus (qspi_rle_fetch_if.master):
//   spi_clk_out/spi_cs_n/spi_d_out/spi_d_oe/spi_d_in to flash,
//   read_next/stop_data in, data_ready/data (FIFO head) out.
// Option: RLE_FETCH_CONTINUE_EN -> restart at the consumed address
//   instead of BASE_ADDR.
module qspi_rle_fetch #(
    parameter logic [23:0] BASE_ADDR = 24'h000000
) (
    input  logic             clk,
    input  logic             rstn,
    qspi_rle_fetch_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_MODE, S_DUMMY, S_DATA
    } state_t;

    localparam logic [7:0] CMD_BYTE = 8'hEB;

    state_t      state_q, state_d;
    state_t      after_state;
    logic        phase_q, phase_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [2:0]  last_cnt;
    logic        idle_done_q, idle_done_d;
    logic [11:0] shift_q, shift_d;
    logic [15:0] mem_q [2];
    logic [15:0] mem_d [2];
    logic        rd_ptr_q, rd_ptr_d;
    logic [1:0]  count_q, count_d;
    logic [23:0] start_addr;
    logic [3:0]  addr_nib;
    logic [15:0] word;
    logic        stall, push, pop;

    // Hold SCK low before a word's first period while no slot is free.
    assign stall = (state_q == S_DATA) && !phase_q &&
                   (cnt_q == 3'd0) && (count_q == 2'd2);
    assign push  = (state_q == S_DATA) && phase_q &&
                   (cnt_q == 3'd3) && !bus.stop_data;
    assign pop   = bus.read_next && (count_q != 2'd0) &&
                   !bus.stop_data;
    assign word  = {shift_q, bus.spi_d_in};

`ifdef RLE_FETCH_CONTINUE_EN
    logic [23:0] consumed_q, consumed_d;

    always_comb begin
        consumed_d = consumed_q;
        if (pop) consumed_d = consumed_q + 24'd2;
    end

    always_ff @(posedge clk) begin
        if (!rstn) consumed_q <= BASE_ADDR;
        else       consumed_q <= consumed_d;
    end

    assign start_addr = consumed_q;
`else
    assign start_addr = BASE_ADDR;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            phase_q     <= 1'b0;
            cnt_q       <= 3'd0;
            // The reset cycle counts as the first IDLE clock.
            idle_done_q <= 1'b1;
            shift_q     <= '0;
            mem_q[0]    <= '0;
            mem_q[1]    <= '0;
            rd_ptr_q    <= 1'b0;
            count_q     <= 2'd0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            cnt_q       <= cnt_d;
            idle_done_q <= idle_done_d;
            shift_q     <= shift_d;
            mem_q       <= mem_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    // Period count and successor of each active state
    always_comb begin
        last_cnt    = 3'd0;
        after_state = S_IDLE;
        unique case (state_q)
            S_CMD:   begin last_cnt = 3'd7; after_state = S_ADDR;  end
            S_ADDR:  begin last_cnt = 3'd5; after_state = S_MODE;  end
            S_MODE:  begin last_cnt = 3'd1; after_state = S_DUMMY; end
            S_DUMMY: begin last_cnt = 3'd3; after_state = S_DATA;  end
            S_DATA:  begin last_cnt = 3'd3; after_state = S_DATA;  end
            default: begin last_cnt = 3'd0; after_state = S_IDLE;  end
        endcase
    end

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        cnt_d       = cnt_q;
        idle_done_d = idle_done_q;
        shift_d     = shift_q;
        if (state_q == S_IDLE) begin
            phase_d     = 1'b0;
            cnt_d       = 3'd0;
            idle_done_d = 1'b1;
            if (idle_done_q) state_d = S_CMD;
        end else begin
            if (!stall) phase_d = ~phase_q;
            if (phase_q) begin
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == last_cnt) begin
                    cnt_d   = 3'd0;
                    state_d = after_state;
                end
            end
        end
        if (state_q == S_DATA && phase_q)
            shift_d = {shift_q[7:0], bus.spi_d_in};
        if (bus.stop_data) begin
            state_d     = S_IDLE;
            phase_d     = 1'b0;
            cnt_d       = 3'd0;
            idle_done_d = 1'b0;
        end
    end

    // FIFO update; a push only ever lands while count <= 1
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (bus.stop_data) begin
            count_d = 2'd0;
        end else begin
            if (push) mem_d[rd_ptr_q ^ count_q[0]] = word;
            if (pop)  rd_ptr_d = ~rd_ptr_q;
            unique case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_comb begin
        unique case (cnt_q)
            3'd0:    addr_nib = start_addr[23:20];
            3'd1:    addr_nib = start_addr[19:16];
            3'd2:    addr_nib = start_addr[15:12];
            3'd3:    addr_nib = start_addr[11:8];
            3'd4:    addr_nib = start_addr[7:4];
            3'd5:    addr_nib = start_addr[3:0];
            default: addr_nib = 4'h0;
        endcase
    end

    // Output logic
    always_comb begin
        bus.spi_cs_n    = 1'b1;
        bus.spi_clk_out = 1'b0;
        bus.spi_d_out   = 4'h0;
        bus.spi_d_oe    = 4'h0;
        if (state_q != S_IDLE) begin
            bus.spi_cs_n    = 1'b0;
            bus.spi_clk_out = phase_q;
        end
        unique case (state_q)
            S_CMD: begin
                bus.spi_d_out = {3'b000, CMD_BYTE[~cnt_q]};
                bus.spi_d_oe  = 4'b0001;
            end
            S_ADDR: begin
                bus.spi_d_out = addr_nib;
                bus.spi_d_oe  = 4'b1111;
            end
            S_MODE: begin
                bus.spi_d_oe  = 4'b1111;
            end
            default: begin
                bus.spi_d_out = 4'h0;
                bus.spi_d_oe  = 4'h0;
            end
        endcase
    end

    assign bus.data_ready = (count_q != 2'd0);
    assign bus.data       = mem_q[rd_ptr_q];
endmodule

// File: tb/tb_qspi_rle_fetch.sv
// Directed bench for qspi_rle_fetch with a behavioural quad-IO flash.
// Flash word at byte address 2*i: 1234,5678,9ABC,DEF0, then A000+i.
module tb_qspi_rle_fetch;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    int n_checks = 0;
    int n_pass = 0;
    int pops = 0;

    qspi_rle_fetch_if bus ();

    qspi_rle_fetch #(.BASE_ADDR(24'h000000)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.master)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] wval(input int i);
        case (i)
            0: return 16'h1234;
            1: return 16'h5678;
            2: return 16'h9ABC;
            3: return 16'hDEF0;
            default: return 16'hA000 + 16'(i);
        endcase
    endfunction

    function automatic logic [3:0] flash_nib(input int pc,
                                             input logic [23:0] a);
        int p;
        logic [15:0] w;
        p = pc - 20;
        w = wval(int'(a >> 1) + p / 4);
        return w[15 - 4 * (p % 4) -: 4];
    endfunction

    int pcnt = 0;
    int addr_cnt = 0;
    int oe_bad = 0;
    logic [7:0] cmd_cap = 8'h00;
    logic [23:0] addr_sh = 24'h0;
    logic [23:0] cap_addr = 24'h0;

    // Flash model: counts SPI periods since CS fell
    always @(posedge clk) begin
        if (bus.spi_cs_n) begin
            pcnt <= 0;
        end else begin
            if (pcnt < 8 && bus.spi_d_oe !== 4'b0001) oe_bad <= oe_bad + 1;
            if (pcnt >= 8 && pcnt < 16 && bus.spi_d_oe !== 4'b1111)
                oe_bad <= oe_bad + 1;
            if (pcnt >= 16 && bus.spi_d_oe !== 4'b0000)
                oe_bad <= oe_bad + 1;
            if (bus.spi_clk_out) begin
                pcnt <= pcnt + 1;
                if (pcnt < 8) begin
                    cmd_cap <= {cmd_cap[6:0], bus.spi_d_out[0]};
                end else if (pcnt < 14) begin
                    addr_sh <= {addr_sh[19:0], bus.spi_d_out};
                    if (pcnt == 13) begin
                        cap_addr <= {addr_sh[19:0], bus.spi_d_out};
                        addr_cnt <= addr_cnt + 1;
                    end
                end
            end
        end
    end

    assign bus.spi_d_in = (!bus.spi_cs_n && pcnt >= 20) ?
                          flash_nib(pcnt, cap_addr) : 4'h0;

    task automatic wait_ready(input string nm);
        int k = 0;
        while (bus.data_ready !== 1'b1 && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (bus.data_ready !== 1'b1) begin
            n_checks++;
            $display("FAIL %s data_ready timeout got %0b want 1",
                     nm, bus.data_ready);
        end
    endtask

    task automatic wait_addr(input int prev, input string nm);
        int k = 0;
        while (addr_cnt == prev && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (addr_cnt == prev) begin
            n_checks++;
            $display("FAIL %s address phase timeout", nm);
        end
    endtask

    task automatic do_pop();
        bus.read_next = 1'b1;
        @(negedge clk);
        bus.read_next = 1'b0;
        pops++;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        bus.read_next = 1'b0;
        bus.stop_data = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus.spi_cs_n !== 1'b1)
            $display("FAIL rst_cs_n got %0b want 1", bus.spi_cs_n);
        else n_pass++;
        n_checks++;
        if (bus.spi_clk_out !== 1'b0)
            $display("FAIL rst_sck got %0b want 0", bus.spi_clk_out);
        else n_pass++;
        n_checks++;
        if (bus.spi_d_out !== 4'h0)
            $display("FAIL rst_d_out got %h want 0", bus.spi_d_out);
        else n_pass++;
        n_checks++;
        if (bus.spi_d_oe !== 4'h0)
            $display("FAIL rst_d_oe got %h want 0", bus.spi_d_oe);
        else n_pass++;
        n_checks++;
        if (bus.data_ready !== 1'b0)
            $display("FAIL rst_ready got %0b want 0", bus.data_ready);
        else n_pass++;
        n_checks++;
        if (bus.data !== 16'h0)
            $display("FAIL rst_data got %h want 0000", bus.data);
        else n_pass++;
    endtask

    task automatic test_first_word();
        rstn = 1'b1;
        pops = 0;
        @(negedge clk);
        n_checks++;
        if (bus.spi_cs_n !== 1'b0 || bus.spi_d_oe !== 4'b0001 ||
            bus.spi_d_out !== 4'b0001 || bus.spi_clk_out !== 1'b0)
            $display("FAIL cmd_start got cs=%0b oe=%b d=%b sck=%0b want 0 0001 0001 0",
                     bus.spi_cs_n, bus.spi_d_oe, bus.spi_d_out,
                     bus.spi_clk_out);
        else n_pass++;
        repeat (47) @(negedge clk);
        n_checks++;
        if (bus.data_ready !== 1'b0)
            $display("FAIL ready_cyc49 got %0b want 0", bus.data_ready);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (bus.data_ready !== 1'b1)
            $display("FAIL ready_cyc50 got %0b want 1", bus.data_ready);
        else n_pass++;
        n_checks++;
        if (bus.data !== 16'h1234)
            $display("FAIL first_data got %h want 1234", bus.data);
        else n_pass++;
        n_checks++;
        if (cmd_cap !== 8'hEB)
            $display("FAIL cmd_byte got %h want eb", cmd_cap);
        else n_pass++;
        n_checks++;
        if (cap_addr !== 24'h000000)
            $display("FAIL first_addr got %h want 000000", cap_addr);
        else n_pass++;
    endtask

    task automatic test_stall();
        repeat (30) @(negedge clk);
        n_checks++;
        if (bus.spi_clk_out !== 1'b0 || bus.spi_cs_n !== 1'b0)
            $display("FAIL stall_pins got sck=%0b cs=%0b want 0 0",
                     bus.spi_clk_out, bus.spi_cs_n);
        else n_pass++;
        n_checks++;
        if (pcnt != 28)
            $display("FAIL stall_periods got %0d want 28", pcnt);
        else n_pass++;
        n_checks++;
        if (bus.data !== 16'h1234)
            $display("FAIL stall_head got %h want 1234", bus.data);
        else n_pass++;
        do_pop();
        n_checks++;
        if (bus.data !== 16'h5678)
            $display("FAIL pop1_head got %h want 5678", bus.data);
        else n_pass++;
        repeat (30) @(negedge clk);
        n_checks++;
        if (pcnt != 32)
            $display("FAIL third_word_periods got %0d want 32", pcnt);
        else n_pass++;
        do_pop();
        n_checks++;
        if (bus.data !== 16'h9ABC)
            $display("FAIL pop2_head got %h want 9abc", bus.data);
        else n_pass++;
        repeat (30) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int k = 0;
        do_pop();
        n_checks++;
        if (bus.data !== 16'hDEF0)
            $display("FAIL pop3_head got %h want def0", bus.data);
        else n_pass++;
        while (!(bus.spi_clk_out === 1'b1 && pcnt >= 20 &&
                 (pcnt - 20) % 4 == 3) && k < 100) begin
            @(negedge clk);
            k++;
        end
        bus.read_next = 1'b1;
        @(negedge clk);
        pops++;
        n_checks++;
        if (bus.data !== 16'hA004 || bus.data_ready !== 1'b1)
            $display("FAIL pushpop got data=%h rdy=%0b want a004 1",
                     bus.data, bus.data_ready);
        else n_pass++;
        @(negedge clk);
        bus.read_next = 1'b0;
        pops++;
        n_checks++;
        if (bus.data_ready !== 1'b0)
            $display("FAIL pushpop_count got rdy=%0b want 0",
                     bus.data_ready);
        else n_pass++;
    endtask

    task automatic test_stop();
        int k = 0;
        int prev;
        logic [23:0] exp;
`ifdef RLE_FETCH_CONTINUE_EN
        exp = 24'(2 * pops);
`else
        exp = 24'h000000;
`endif
        while (!(bus.spi_cs_n === 1'b0 && pcnt >= 20 &&
                 (pcnt - 20) % 4 == 1) && k < 100) begin
            @(negedge clk);
            k++;
        end
        bus.stop_data = 1'b1;
        prev = addr_cnt;
        @(negedge clk);
        bus.stop_data = 1'b0;
        n_checks++;
        if (bus.spi_cs_n !== 1'b1 || bus.data_ready !== 1'b0 ||
            bus.spi_clk_out !== 1'b0)
            $display("FAIL stop_abort got cs=%0b rdy=%0b sck=%0b want 1 0 0",
                     bus.spi_cs_n, bus.data_ready, bus.spi_clk_out);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (bus.spi_cs_n !== 1'b1)
            $display("FAIL stop_idle2 got cs=%0b want 1", bus.spi_cs_n);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (bus.spi_cs_n !== 1'b0)
            $display("FAIL stop_restart got cs=%0b want 0", bus.spi_cs_n);
        else n_pass++;
        wait_addr(prev, "stop");
        n_checks++;
        if (cap_addr !== exp)
            $display("FAIL stop_addr got %h want %h", cap_addr, exp);
        else n_pass++;
        wait_ready("stop");
        n_checks++;
        if (bus.data !== wval(int'(exp >> 1)))
            $display("FAIL stop_word got %h want %h",
                     bus.data, wval(int'(exp >> 1)));
        else n_pass++;
    endtask

    task automatic test_continue();
        int prev;
        logic [23:0] exp;
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        pops = 0;
        bus.read_next = 1'b1;
        @(negedge clk);
        bus.read_next = 1'b0;
        n_checks++;
        if (bus.data_ready !== 1'b0)
            $display("FAIL empty_pop got rdy=%0b want 0", bus.data_ready);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            wait_ready("cont");
            n_checks++;
            if (bus.data !== wval(i))
                $display("FAIL cont_word%0d got %h want %h",
                         i, bus.data, wval(i));
            else n_pass++;
            do_pop();
        end
`ifdef RLE_FETCH_CONTINUE_EN
        exp = 24'h000006;
`else
        exp = 24'h000000;
`endif
        prev = addr_cnt;
        bus.stop_data = 1'b1;
        @(negedge clk);
        bus.stop_data = 1'b0;
        wait_addr(prev, "cont");
        n_checks++;
        if (cap_addr !== exp)
            $display("FAIL cont_addr got %h want %h", cap_addr, exp);
        else n_pass++;
        wait_ready("cont_restart");
        n_checks++;
        if (bus.data !== wval(int'(exp >> 1)))
            $display("FAIL cont_word got %h want %h",
                     bus.data, wval(int'(exp >> 1)));
        else n_pass++;
    endtask

    task automatic test_reset_dummy();
        int k = 0;
        int prev;
        bus.stop_data = 1'b1;
        @(negedge clk);
        bus.stop_data = 1'b0;
        repeat (3) @(negedge clk);
        while (!(bus.spi_cs_n === 1'b0 && pcnt >= 16 && pcnt < 20) &&
               k < 100) begin
            @(negedge clk);
            k++;
        end
        rstn = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.spi_cs_n !== 1'b1 || bus.spi_clk_out !== 1'b0)
            $display("FAIL dummy_rst_pins got cs=%0b sck=%0b want 1 0",
                     bus.spi_cs_n, bus.spi_clk_out);
        else n_pass++;
        n_checks++;
        if (bus.spi_d_out !== 4'h0 || bus.spi_d_oe !== 4'h0)
            $display("FAIL dummy_rst_io got d=%h oe=%h want 0 0",
                     bus.spi_d_out, bus.spi_d_oe);
        else n_pass++;
        n_checks++;
        if (bus.data_ready !== 1'b0 || bus.data !== 16'h0)
            $display("FAIL dummy_rst_fifo got rdy=%0b data=%h want 0 0000",
                     bus.data_ready, bus.data);
        else n_pass++;
        rstn = 1'b1;
        prev = addr_cnt;
        wait_addr(prev, "dummy");
        n_checks++;
        if (cap_addr !== 24'h000000)
            $display("FAIL dummy_addr got %h want 000000", cap_addr);
        else n_pass++;
        wait_ready("dummy");
        n_checks++;
        if (bus.data !== 16'h1234)
            $display("FAIL dummy_word got %h want 1234", bus.data);
        else n_pass++;
        n_checks++;
        if (oe_bad != 0)
            $display("FAIL oe_pattern got %0d bad periods want 0", oe_bad);
        else n_pass++;
    endtask

    initial begin
        bus.read_next = 1'b0;
        bus.stop_data = 1'b0;
        test_reset();
        test_first_word();
        test_stall();
        test_back_to_back();
        test_stop();
        test_continue();
        test_reset_dummy();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
